tk1_rewind: RTL and testbench
=============================

# tk1_rewind

Sequential inverse TK1 tweakey-schedule unit for the Romulus SKINNY-128-384+ core. It loads a 128-bit TK1 state and a round count R, then applies the inverse tweakey permutation P⁻¹ R times. Each cycle it takes either eight steps or one step. The result is the TK1 value R rounds earlier, which the decryption/inverse-round datapath needs. It is the reverse-direction counterpart of the forward 8-round TK1 permutation path.

## Interface
Parameters:
- CNT_W, 6, width of the round-count input (R max = 2^CNT_W − 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  a load request is present.
- in_ready  out  1  unit can accept a load.
- tk1i  in  128  TK1 state to rewind. Cell 0 = bits [127:120], cell 15 = bits [7:0].
- rounds  in  CNT_W  number of inverse rounds R.
- out_valid  out  1  tk1o holds the finished result.
- out_ready  in  1  consumer accepts the result.
- tk1o  out  128  rewound TK1 state.

## Operation
- Forward permutation P = [9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7], where Y[i] = X[P[i]].
- Inverse permutation: Y[P[i]] = X[i]. P has order 16, so P⁻⁸ = P⁸.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - When in_valid & in_ready: state reg ← tk1i and cnt ← rounds.
    - Next state is RUN if rounds ≠ 0, else DONE.
  - RUN:
    - Each cycle, if cnt ≥ 8: apply P⁻⁸ and cnt −= 8.
    - Otherwise: apply P⁻¹ and cnt −= 1.
    - Go to DONE on the step that makes cnt = 0.
  - DONE:
    - out_valid = 1 and tk1o = state reg, both held stable.
    - When out_ready is high: go to IDLE.
- in_ready is high only in IDLE. No new load is accepted in the cycle a result is consumed.
- The inputs tk1i and rounds are sampled only on the accepting edge. Changes after that have no effect.
- Reset, asserted at any time including mid-RUN:
  - Aborts the operation immediately, with no partial output.
  - State → IDLE, cnt = 0, state reg = 0, out_valid = 0, tk1o = 0.
  - in_ready = 1 from the first cycle after reset deassertion.
- tk1o is a direct register output. It is not combinational from the inputs.

## Timing
- Accept edge t0. Number of RUN cycles N = ⌊R/8⌋ + (R mod 8).
- out_valid rises after edge t0 + N.
- R = 0: out_valid is high right after t0, and tk1o = tk1i.
- Example N values:
  - R = 1 → N = 1.
  - R = 8 → N = 1.
  - R = 16 → N = 2.
  - R = 40 → N = 5.
  - R = 63 → N = 14 (worst case for CNT_W = 6).
- Throughput: one operation per N + 2 cycles minimum (accept cycle + RUN cycles + handshake cycle).
- out_ready held low: DONE persists indefinitely with tk1o unchanged.
- out_ready already high when DONE is entered: consumed on the first DONE edge, and the unit is back in IDLE the cycle after.

## Structure
- Shared package (romulus_pkg): the permutation table P as a constant, and the CNT_W default.
- One natural sub-module: inv_permutation, a combinational 128→128 single-step P⁻¹.
- The P⁻⁸ path chains eight inv_permutation instances in the same style as the forward 8-step chain.
- Remaining logic in the top module:
  - 2-bit FSM.
  - cnt register.
  - 2:1 step mux (P⁻⁸ or P⁻¹).
  - 128-bit state register.

## Test plan
- R = 1, tk1i = 0x000102030405060708090a0b0c0d0e0f → tk1o = 0x08090a0b0c0d0e0f0200040706030501, out_valid after 1 RUN cycle.
- R = 16, arbitrary tk1i → tk1o = tk1i (order 16), N = 2. R = 0 → tk1o = tk1i, out_valid the cycle after accept.
- Round trip: apply the forward 8-step permutation 5× to random X, then rewind with R = 40 → tk1o = X, N = 5. Repeat with R = 63 on P⁶³(X) → X, N = 14.
- Backpressure: out_ready low for 10 cycles in DONE → out_valid and tk1o stable, in_ready = 0, in_valid pulses ignored. out_ready high → IDLE next cycle.
- Reset mid-RUN, with R = 63 at cycle 5 → outputs 0, out_valid = 0, in_ready = 1 after release. A fresh R = 1 load then produces the correct result.
- Input change after accept: modify tk1i/rounds during RUN → result matches the values sampled at accept.

Source files
------------

// File: rtl/romulus_pkg.sv
// Shared constants for the Romulus SKINNY-128-384+ tweakey datapath.
// TK_PERM is the forward TK permutation: Y[i] = X[TK_PERM[i]], cell 0 = bits [127:120].
package romulus_pkg;

  localparam int unsigned CNT_W_DEF = 6;

  localparam int unsigned TK_PERM [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                                           0, 1, 2, 3, 4, 5, 6, 7};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rw_state_e;

endpackage

// File: rtl/tk1_rewind_inv_permutation.sv
// Combinational single-step inverse TK permutation: Y[P[i]] = X[i].
module inv_permutation
  import romulus_pkg::*;
(
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);

  always_comb begin
    y_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      y_o[127 - 8*TK_PERM[i] -: 8] = x_i[127 - 8*i -: 8];
    end
  end

endmodule

// File: rtl/tk1_rewind.sv
// Sequential TK1 rewind: applies P^-1 R times, eight steps per cycle while R >= 8.
// Load/result use a valid/ready handshake; tk1o is the state register itself.
module tk1_rewind
  import romulus_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     tk1i,
  input  logic [CNT_W-1:0] rounds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     tk1o
);

  localparam logic [CNT_W-1:0] STEP8 = CNT_W'(8);
  localparam logic [CNT_W-1:0] STEP1 = CNT_W'(1);

  rw_state_e        fsm_q;
  logic [127:0]     state_q;
  logic [127:0]     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [127:0] chain [0:8];

  assign chain[0] = state_q;

  for (genvar g = 0; g < 8; g++) begin : g_inv
    inv_permutation u_inv (
      .x_i (chain[g]),
      .y_o (chain[g+1])
    );
  end

  always_comb begin
    state_d = chain[1];
    cnt_d   = cnt_q - STEP1;
    if (cnt_q >= STEP8) begin
      state_d = chain[8];
      cnt_d   = cnt_q - STEP8;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= tk1i;
            cnt_q      <= rounds;
            in_ready_q <= 1'b0;
            if (rounds != '0) begin
              fsm_q <= ST_RUN;
            end else begin
              fsm_q       <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          if (cnt_d == '0) begin
            fsm_q       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          // Back to IDLE only; a load cannot share the consume cycle.
          if (out_ready) begin
            fsm_q       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm_q       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign tk1o      = state_q;

endmodule

// File: tb/tb_tk1_rewind.sv
// Directed bench for tk1_rewind: expected values come from hand vectors and a forward-P model.
module tb_tk1_rewind;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] tk1i;
  logic [5:0]   rounds;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] tk1o;

  int total;
  int bad;

  int unsigned FWD [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  tk1_rewind #(.CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tk1i      (tk1i),
    .rounds    (rounds),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tk1o      (tk1o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] fwd_n(input logic [127:0] x, input int n);
    logic [127:0] cur;
    logic [127:0] nxt;
    cur = x;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 16; i++) begin
        nxt[127 - 8*i -: 8] = cur[127 - 8*FWD[i] -: 8];
      end
      cur = nxt;
    end
    return cur;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] tk, input logic [5:0] r);
    @(negedge clk);
    chk("in_ready_before_load", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    tk1i     = tk;
    rounds   = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_consume", {127'd0, in_ready}, 128'd1);
    chk("out_valid_after_consume", {127'd0, out_valid}, 128'd0);
  endtask

  task automatic run_case(input string tag, input logic [127:0] tk, input logic [5:0] r,
                          input logic [127:0] exp, input int exp_n);
    int n;
    load(tk, r);
    wait_done(n);
    chk({tag, "_cycles"}, 128'(n), 128'(exp_n));
    chk({tag, "_tk1o"}, tk1o, exp);
    consume();
  endtask

  logic [127:0] vec0;
  logic [127:0] res0;
  logic [127:0] x;
  logic [127:0] held;
  int           n;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tk1i      = '0;
    rounds    = '0;
    vec0      = 128'h000102030405060708090a0b0c0d0e0f;
    res0      = 128'h08090a0b0c0d0e0f0200040706030501;

    #12;
    chk("reset_tk1o", tk1o, 128'd0);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {127'd0, in_ready}, 128'd1);

    run_case("r1", vec0, 6'd1, res0, 1);
    run_case("r8", vec0, 6'd8, fwd_n(vec0, 8), 1);

    x = {$urandom, $urandom, $urandom, $urandom};
    run_case("r16", x, 6'd16, x, 2);
    run_case("r0", x, 6'd0, x, 0);

    x = {$urandom, $urandom, $urandom, $urandom};
    run_case("rt40", fwd_n(x, 40), 6'd40, x, 5);
    x = {$urandom, $urandom, $urandom, $urandom};
    run_case("rt63", fwd_n(x, 63), 6'd63, x, 14);

    // Inputs altered right after the accept edge must not affect the result.
    x = {$urandom, $urandom, $urandom, $urandom};
    load(fwd_n(x, 40), 6'd40);
    tk1i   = ~tk1i;
    rounds = 6'd3;
    wait_done(n);
    chk("chg_cycles", 128'(n), 128'd5);
    chk("chg_tk1o", tk1o, x);

    // Backpressure with stray load pulses.
    held = tk1o;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      tk1i     = {$urandom, $urandom, $urandom, $urandom};
      rounds   = 6'd1;
      @(negedge clk);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_tk1o", tk1o, x);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    chk("bp_no_stray_load", tk1o, held);
    chk("bp_idle_out_valid", {127'd0, out_valid}, 128'd0);

    // out_ready already high on DONE entry: one DONE cycle, then IDLE.
    out_ready = 1'b1;
    load(vec0, 6'd1);
    wait_done(n);
    chk("rdy_cycles", 128'(n), 128'd1);
    chk("rdy_tk1o", tk1o, res0);
    @(negedge clk);
    chk("rdy_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rdy_out_valid", {127'd0, out_valid}, 128'd0);
    out_ready = 1'b0;

    // Reset in the middle of a long rewind.
    load({$urandom, $urandom, $urandom, $urandom}, 6'd63);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_tk1o", tk1o, 128'd0);
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("midrst_idle_tk1o", tk1o, 128'd0);
    chk("midrst_idle_out_valid", {127'd0, out_valid}, 128'd0);
    run_case("post_rst_r1", vec0, 6'd1, res0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
